// File: rtl/move_cmd_scheduler.sv
// Movement command scheduler: FIFO intake, one-at-a-time issue, per-frame quota.
// Optional OPPOSITE_CANCEL_EN: an opposite request removes the FIFO tail.
module move_cmd_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_CMDS_PER_FRAME = 1,
  parameter int TIMEOUT_CYCLES = 1023,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1,
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          fwd_pulse,
  input  logic          bwd_pulse,
  input  logic          leftRot_pulse,
  input  logic          rightRot_pulse,
  input  logic          frame_switch,
  output logic          cmd_valid,
  output logic [1:0]    cmd_op,
  input  logic          cmd_ready,
  input  logic          done_in,
  output logic          commit_out,
  output logic          busy_out,
  output logic [CW-1:0] fifo_count,
  output logic [7:0]    drop_count,
  output logic          timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } state_e;

  state_e        state_q;
  logic [1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    fcmd_q;
  logic [TW-1:0] tmr_q;
  logic          pend_q;
  logic          commit_q;
  logic          valid_q;
  logic          terr_q;
  logic [1:0]    op_q;
  logic [7:0]    drop_q;

  logic          req;
  logic [1:0]    req_op;
  logic [2:0]    npulse;
  logic          full;
  logic          hs;
  logic          push;
  logic          cancel;
  logic          go;
  logic [2:0]    drop_inc;
  logic [8:0]    drop_sum;
  logic [AW-1:0] tail_ptr;

  always_comb begin
    npulse = 3'(fwd_pulse) + 3'(bwd_pulse)
           + 3'(leftRot_pulse) + 3'(rightRot_pulse);
    req = (npulse != 3'd0);
    priority case (1'b1)
      fwd_pulse:     req_op = 2'd0;
      bwd_pulse:     req_op = 2'd1;
      leftRot_pulse: req_op = 2'd2;
      default:       req_op = 2'd3;
    endcase
  end

  assign tail_ptr = wr_q - AW'(1);

`ifdef OPPOSITE_CANCEL_EN
  logic [1:0] tail_op;
  assign tail_op = mem_q[tail_ptr];
  // The head being offered in ISSUE must not vanish under the engine.
  assign cancel = req && (cnt_q != '0)
                && ((req_op ^ 2'b01) == tail_op)
                && !((state_q == ISSUE) && (cnt_q == CW'(1)));
`else
  assign cancel = 1'b0;
`endif

  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign hs       = valid_q & cmd_ready;
  assign push     = req & ~cancel & ~full;
  assign drop_inc = (req ? (npulse - 3'd1) : 3'd0)
                  + 3'(req & ~cancel & full);
  assign drop_sum = 9'(drop_q) + 9'(drop_inc);
  assign go       = (cnt_q != '0)
                  && !(cancel && (cnt_q == CW'(1)))
                  && (fcmd_q < 4'(MAX_CMDS_PER_FRAME));

  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_q] <= req_op;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
      fcmd_q   <= '0;
      tmr_q    <= '0;
      pend_q   <= 1'b0;
      commit_q <= 1'b0;
      valid_q  <= 1'b0;
      terr_q   <= 1'b0;
      op_q     <= '0;
      drop_q   <= '0;
    end else begin
      if (push)   wr_q <= wr_q + AW'(1);
      if (cancel) wr_q <= tail_ptr;
      if (hs)     rd_q <= rd_q + AW'(1);
      cnt_q    <= cnt_q + CW'(push) - CW'(hs) - CW'(cancel);
      drop_q   <= (drop_sum > 9'd255) ? 8'hff : drop_sum[7:0];
      fcmd_q   <= (frame_switch ? 4'd0 : fcmd_q) + 4'(hs);
      commit_q <= frame_switch & pend_q;
      if (frame_switch) pend_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (go) begin
            state_q <= ISSUE;
            valid_q <= 1'b1;
            op_q    <= mem_q[rd_q];
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            state_q <= WAIT_DONE;
            valid_q <= 1'b0;
            tmr_q   <= '0;
          end
        end
        WAIT_DONE: begin
          if (done_in) begin
            pend_q  <= 1'b1;
            state_q <= IDLE;
          end else if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
            terr_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_valid   = valid_q;
  assign cmd_op      = op_q;
  assign commit_out  = commit_q;
  assign busy_out    = (state_q != IDLE) || (cnt_q != '0);
  assign fifo_count  = cnt_q;
  assign drop_count  = drop_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_move_cmd_scheduler.sv
// Randomized scoreboard bench for move_cmd_scheduler.
// Reference model tracks queue contents, quota and commit rules per cycle.
module tb_move_cmd_scheduler;
  localparam int DEPTH = 4;
  localparam int MAXC  = 1;
  localparam int TMO   = 1023;

  logic clk = 1'b0;
  logic rst, fwd, bwd, lft, rgt, fs, rdy, dn;
  logic cmd_valid, commit_out, busy_out, timeout_err;
  logic [1:0] cmd_op;
  logic [2:0] fifo_count;
  logic [7:0] drop_count;

  always #5 clk = ~clk;

  move_cmd_scheduler #(
    .FIFO_DEPTH(DEPTH),
    .MAX_CMDS_PER_FRAME(MAXC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .fwd_pulse(fwd),
    .bwd_pulse(bwd),
    .leftRot_pulse(lft),
    .rightRot_pulse(rgt),
    .frame_switch(fs),
    .cmd_valid(cmd_valid),
    .cmd_op(cmd_op),
    .cmd_ready(rdy),
    .done_in(dn),
    .commit_out(commit_out),
    .busy_out(busy_out),
    .fifo_count(fifo_count),
    .drop_count(drop_count),
    .timeout_err(timeout_err)
  );

  int errors = 0;
  int checks = 0;
  int m_q[$];
  int sb[$];
  bit m_offer, m_wait, m_pend, m_commit, m_terr;
  bit started = 0;
  bit auto_done = 0;
  int m_wcnt, m_used, m_drops, m_op;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs();
    if (!started) return;
    check("cmd_valid", 32'(cmd_valid), 32'(m_offer));
    if (m_offer) check("cmd_op", 32'(cmd_op), m_op);
    check("fifo_count", 32'(fifo_count), m_q.size());
    check("drop_count", 32'(drop_count), (m_drops > 255) ? 255 : m_drops);
    check("commit_out", 32'(commit_out), 32'(m_commit));
    check("busy_out", 32'(busy_out),
          32'(m_offer || m_wait || (m_q.size() > 0)));
    check("timeout_err", 32'(timeout_err), 32'(m_terr));
  endtask

  task automatic model_step();
    int n, op, sz;
    bit hs, cancel, launch;
    started = 1;
    if (rst) begin
      m_q.delete();
      sb.delete();
      m_offer = 0; m_wait = 0; m_pend = 0; m_commit = 0; m_terr = 0;
      m_wcnt = 0; m_used = 0; m_drops = 0; m_op = 0;
      return;
    end
    sz = m_q.size();
    n = int'(fwd) + int'(bwd) + int'(lft) + int'(rgt);
    op = fwd ? 0 : bwd ? 1 : lft ? 2 : 3;
    hs = m_offer && rdy;
    cancel = 0;
`ifdef OPPOSITE_CANCEL_EN
    if (n > 0 && sz > 0 && m_q[sz-1] == (op ^ 1) && !(m_offer && sz == 1))
      cancel = 1;
`endif
    launch = !m_offer && !m_wait && sz > 0 && !(cancel && sz == 1)
             && m_used < MAXC;
    if (n > 0) m_drops += n - 1;
    if (n > 0 && !cancel && sz >= DEPTH) m_drops++;
    m_commit = fs && m_pend;
    if (fs) m_pend = 0;
    m_used = (fs ? 0 : m_used) + (hs ? 1 : 0);
    if (m_offer) begin
      if (rdy) begin
        m_offer = 0; m_wait = 1; m_wcnt = 0;
        void'(m_q.pop_front());
      end
    end else if (m_wait) begin
      if (dn) begin
        m_pend = 1; m_wait = 0;
      end else begin
        m_wcnt++;
        if (m_wcnt == TMO) begin
          m_terr = 1; m_wait = 0;
        end
      end
    end else if (launch) begin
      m_offer = 1;
      m_op = m_q[0];
    end
    if (cancel) begin
      void'(m_q.pop_back());
      if (sb.size() > 0) void'(sb.pop_back());
    end else if (n > 0 && sz < DEPTH) begin
      m_q.push_back(op);
      sb.push_back(op);
    end
  endtask

  task automatic cycle(bit f, bit b, bit l, bit r, bit s,
                       bit rd, bit d, bit rs);
    @(negedge clk);
    check_outputs();
    #1;
    fwd = f; bwd = b; lft = l; rgt = r; fs = s; rdy = rd; rst = rs;
    dn = d | (auto_done & m_wait);
    model_step();
  endtask

  task automatic idle(int n, bit rd);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, rd, 0, 0);
  endtask

  task automatic drain();
    auto_done = 1;
    for (int i = 0; i < 60; i++) cycle(0, 0, 0, 0, (i % 6) == 5, 1, 0, 0);
    auto_done = 0;
  endtask

  // Monitor: pops expected ops on each observed handshake.
  initial begin
    bit pv;
    int pop;
    pv = 0;
    pop = 0;
    forever begin
      @(negedge clk);
      #3;
      if (started && !rst) begin
        if (pv) begin
          check("valid_held", 32'(cmd_valid), 1);
          check("op_stable", 32'(cmd_op), pop);
        end
        if (cmd_valid && rdy) begin
          check("sb_nonempty", 32'(sb.size() > 0), 1);
          if (sb.size() > 0) check("sb_op", 32'(cmd_op), sb.pop_front());
        end
        pv = cmd_valid && !rdy;
        pop = int'(cmd_op);
      end else begin
        pv = 0;
      end
    end
  end

  initial begin
    fwd = 0; bwd = 0; lft = 0; rgt = 0; fs = 0; rdy = 0; dn = 0; rst = 1;
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    check("rst_valid", 32'(cmd_valid), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_drop", 32'(drop_count), 0);
    check("rst_busy", 32'(busy_out), 0);

    cycle(1, 0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    check("t1_count", 32'(fifo_count), 1);
    check("t1_valid_early", 32'(cmd_valid), 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    check("t1_valid", 32'(cmd_valid), 1);
    check("t1_op", 32'(cmd_op), 0);
    idle(4, 1);
    cycle(0, 0, 0, 0, 0, 1, 1, 0);
    idle(2, 1);
    cycle(0, 0, 0, 0, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    check("t1_commit", 32'(commit_out), 1);

    cycle(1, 0, 1, 1, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    check("t2_drop", 32'(drop_count), 2);
    check("t2_count", 32'(fifo_count), 1);
    drain();

    cycle(0, 0, 0, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check("t3_count", 32'(fifo_count), 4);
    check("t3_drop", 32'(drop_count), 3);
    check("t3_valid", 32'(cmd_valid), 1);
    check("t3_op", 32'(cmd_op), 0);
    idle(6, 0);
    drain();

    cycle(0, 0, 0, 0, 1, 1, 0, 0);
    auto_done = 1;
    cycle(1, 0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 40; i++) cycle(0, 0, 0, 0, (i % 8) == 7, 1, 0, 0);
    auto_done = 0;
    drain();

    cycle(0, 0, 0, 0, 1, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 0, 0);
    cycle(0, 1, 0, 0, 0, 1, 0, 0);
    idle(1040, 1);
    check("t5_terr", 32'(timeout_err), 1);
    check("t5_count", 32'(fifo_count), 1);
    check("t5_idle_valid", 32'(cmd_valid), 0);
    cycle(0, 0, 0, 0, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    check("t5_nocommit", 32'(commit_out), 0);
    drain();

    cycle(0, 0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef OPPOSITE_CANCEL_EN
    check("t6_count", 32'(fifo_count), 1);
`else
    check("t6_count", 32'(fifo_count), 3);
`endif
    check("t6_head", 32'(cmd_op), 2);
    drain();

    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom % 6) == 0, ($urandom % 6) == 0,
            ($urandom % 6) == 0, ($urandom % 6) == 0,
            ($urandom % 8) == 0, ($urandom % 3) != 0,
            m_wait ? (($urandom % 4) == 0) : (($urandom % 16) == 0),
            i == 2000);
    end
    @(negedge clk);
    check_outputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
